// File: rtl/ss_write_data_if.sv
// ss_write_data_if: framed byte stream in, RAM write port and read-stage handoff out
interface ss_write_data_if #(parameter int SIZE_ADDR = 6, parameter int SIZE_DATA = 8);
  logic [SIZE_DATA-1:0] i_data;
  logic                 i_data_valid;
  logic                 i_data_last;
  logic                 o_ready;
  logic                 o_we_ram;
  logic [SIZE_ADDR-1:0] o_addr_ram;
  logic [SIZE_DATA-1:0] o_data_ram;
  logic [SIZE_ADDR-1:0] o_si_ram;
  logic [SIZE_ADDR-1:0] o_ei_ram;
  logic                 o_start_read_data;
  logic                 o_en_read_data;
  logic                 i_done_read_data;
  logic                 o_trunc;
  modport slave (
    input  i_data, i_data_valid, i_data_last, i_done_read_data,
    output o_ready, o_we_ram, o_addr_ram, o_data_ram, o_si_ram, o_ei_ram,
           o_start_read_data, o_en_read_data, o_trunc
  );
  modport master (
    output i_data, i_data_valid, i_data_last, i_done_read_data,
    input  o_ready, o_we_ram, o_addr_ram, o_data_ram, o_si_ram, o_ei_ram,
           o_start_read_data, o_en_read_data, o_trunc
  );
endinterface

// File: rtl/ss_write_data.sv
// ss_write_data: writes framed beats into a circular RAM and hands each frame to the read stage
module ss_write_data #(parameter int SIZE_ADDR = 6, parameter int SIZE_DATA = 8) (
  input logic            i_clk,
  input logic            i_rst,
  ss_write_data_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, HANDOFF} state_t;
  localparam logic [SIZE_ADDR:0] DEPTH = {1'b1, {SIZE_ADDR{1'b0}}};
  state_t               state_q, state_d;
  logic [SIZE_ADDR-1:0] wr_ptr_q, wr_ptr_d, si_q, si_d;
  logic [SIZE_ADDR:0]   cnt_q, cnt_d, cnt_inc;
  logic                 we_q, we_d, trunc_q, trunc_d;
  logic [SIZE_ADDR-1:0] addr_q, addr_d, si_ram_q, si_ram_d, ei_ram_q, ei_ram_d;
  logic [SIZE_DATA-1:0] data_q, data_d;
  logic                 ready, accept, last_beat;
  assign ready = ~i_rst & (state_q == IDLE | state_q == WRITE);
  // a frame ends on an explicit last or when it has filled the whole RAM
  always_comb begin
    accept    = bus.i_data_valid & ready;
    cnt_inc   = cnt_q + 1'b1;
    last_beat = accept & (bus.i_data_last | (state_q == WRITE & cnt_inc == DEPTH));
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (last_beat ? FLUSH : WRITE) : IDLE;
      WRITE:   state_d = last_beat ? FLUSH : WRITE;
      FLUSH:   state_d = HANDOFF;
      HANDOFF: state_d = bus.i_done_read_data ? IDLE : HANDOFF;
      default: state_d = IDLE;
    endcase
    cnt_d    = accept ? (state_q == IDLE ? {{SIZE_ADDR{1'b0}}, 1'b1} : cnt_inc) : cnt_q;
    si_d     = (accept & state_q == IDLE) ? wr_ptr_q : si_q;
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    we_d     = accept;
    addr_d   = accept ? wr_ptr_q : addr_q;
    data_d   = accept ? bus.i_data : data_q;
    si_ram_d = last_beat ? (state_q == IDLE ? wr_ptr_q : si_q) : si_ram_q;
    ei_ram_d = last_beat ? wr_ptr_q : ei_ram_q;
    trunc_d  = last_beat & ~bus.i_data_last;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      si_q     <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      si_ram_q <= '0;
      ei_ram_q <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      si_q     <= si_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      si_ram_q <= si_ram_d;
      ei_ram_q <= ei_ram_d;
      trunc_q  <= trunc_d;
    end
  end
  assign bus.o_ready           = ready;
  assign bus.o_we_ram          = we_q;
  assign bus.o_addr_ram        = addr_q;
  assign bus.o_data_ram        = data_q;
  assign bus.o_si_ram          = si_ram_q;
  assign bus.o_ei_ram          = ei_ram_q;
  assign bus.o_trunc           = trunc_q;
  assign bus.o_start_read_data = state_q == HANDOFF;
  assign bus.o_en_read_data    = state_q == HANDOFF;
endmodule

// File: tb/tb_ss_write_data.sv
// tb_ss_write_data: directed frames covering handoff, wrap, truncation, single-beat and reset
module tb_ss_write_data;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  ss_write_data_if bus ();
  ss_write_data dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    bus.i_data       = d;
    bus.i_data_valid = 1'b1;
    bus.i_data_last  = l;
    tick();
    bus.i_data_valid = 1'b0;
    bus.i_data_last  = 1'b0;
  endtask
  task automatic done();
    bus.i_done_read_data = 1'b1;
    tick();
    bus.i_done_read_data = 1'b0;
  endtask
  task automatic chk_frame(input string tag, input logic [5:0] si, input logic [5:0] ei);
    chk({tag, "_si"}, bus.o_si_ram, si);
    chk({tag, "_ei"}, bus.o_ei_ram, ei);
    chk({tag, "_flush_ready"}, bus.o_ready, 0);
    chk({tag, "_flush_start"}, bus.o_start_read_data, 0);
    tick();
    chk({tag, "_start"}, bus.o_start_read_data, 1);
    chk({tag, "_en"}, bus.o_en_read_data, 1);
    chk({tag, "_we_idle"}, bus.o_we_ram, 0);
    done();
    chk({tag, "_start_drop"}, bus.o_start_read_data, 0);
    chk({tag, "_en_drop"}, bus.o_en_read_data, 0);
    chk({tag, "_ready_back"}, bus.o_ready, 1);
  endtask
  initial begin
    logic [7:0] f1 [4];
    logic [5:0] a;
    f1[0] = 8'h11; f1[1] = 8'h22; f1[2] = 8'h33; f1[3] = 8'h44;
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    bus.i_data_last = 1'b0;
    bus.i_done_read_data = 1'b0;
    #1;
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_we", bus.o_we_ram, 0);
    chk("rst_addr", bus.o_addr_ram, 0);
    chk("rst_data", bus.o_data_ram, 0);
    chk("rst_si", bus.o_si_ram, 0);
    chk("rst_ei", bus.o_ei_ram, 0);
    chk("rst_start", bus.o_start_read_data, 0);
    chk("rst_en", bus.o_en_read_data, 0);
    chk("rst_trunc", bus.o_trunc, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ready", bus.o_ready, 1);
    bus.i_data_last = 1'b1;
    tick();
    bus.i_data_last = 1'b0;
    chk("last_no_valid_we", bus.o_we_ram, 0);
    chk("last_no_valid_ready", bus.o_ready, 1);
    for (int i = 0; i < 4; i++) begin
      send(f1[i], i == 3);
      chk("f1_we", bus.o_we_ram, 1);
      chk("f1_addr", bus.o_addr_ram, i);
      chk("f1_data", bus.o_data_ram, f1[i]);
    end
    chk_frame("f1", 6'd0, 6'd3);
    for (int i = 0; i < 3; i++) begin
      send(8'hA1 + 8'(i), i == 2);
      chk("f2_addr", bus.o_addr_ram, 4 + i);
      chk("f2_gap_start", bus.o_start_read_data, 0);
    end
    chk_frame("f2", 6'd4, 6'd6);
    for (int i = 0; i < 55; i++) begin
      send(8'(i), i == 54);
      chk("pre_addr", bus.o_addr_ram, 7 + i);
    end
    chk_frame("pre", 6'd7, 6'd61);
    for (int i = 0; i < 4; i++) begin
      send(8'hC0 + 8'(i), i == 3);
      a = 6'd62 + 6'(i);
      chk("wrap_addr", bus.o_addr_ram, a);
      chk("wrap_data", bus.o_data_ram, 8'hC0 + 8'(i));
    end
    chk_frame("wrap", 6'd62, 6'd1);
    for (int i = 0; i < 64; i++) begin
      chk("tr_ready", bus.o_ready, 1);
      send(8'(i), 1'b0);
      a = 6'd2 + 6'(i);
      chk("tr_addr", bus.o_addr_ram, a);
      chk("tr_we", bus.o_we_ram, 1);
      if (i < 63) chk("tr_no_trunc", bus.o_trunc, 0);
    end
    chk("tr_trunc", bus.o_trunc, 1);
    chk("tr_si", bus.o_si_ram, 2);
    chk("tr_ei", bus.o_ei_ram, 1);
    chk("tr_flush_ready", bus.o_ready, 0);
    bus.i_data = 8'hEE;
    bus.i_data_valid = 1'b1;
    bus.i_data_last = 1'b1;
    tick();
    chk("tr_trunc_pulse", bus.o_trunc, 0);
    chk("tr_hold_ready", bus.o_ready, 0);
    chk("tr_hold_we", bus.o_we_ram, 0);
    chk("tr_start", bus.o_start_read_data, 1);
    bus.i_done_read_data = 1'b1;
    tick();
    bus.i_done_read_data = 1'b0;
    chk("tr_done_valid_we", bus.o_we_ram, 0);
    chk("tr_done_start", bus.o_start_read_data, 0);
    chk("tr_done_ready", bus.o_ready, 1);
    tick();
    bus.i_data_valid = 1'b0;
    bus.i_data_last = 1'b0;
    chk("tr_b65_we", bus.o_we_ram, 1);
    chk("tr_b65_addr", bus.o_addr_ram, 2);
    chk("tr_b65_data", bus.o_data_ram, 8'hEE);
    chk_frame("tr_b65", 6'd2, 6'd2);
    done();
    chk("early_done_ready", bus.o_ready, 1);
    chk("early_done_start", bus.o_start_read_data, 0);
    send(8'h5A, 1'b1);
    chk("single_addr", bus.o_addr_ram, 3);
    chk("single_data", bus.o_data_ram, 8'h5A);
    chk("single_si", bus.o_si_ram, 3);
    chk("single_ei", bus.o_ei_ram, 3);
    tick();
    chk("single_start", bus.o_start_read_data, 1);
    rst = 1'b1;
    #1;
    chk("hrst_start", bus.o_start_read_data, 0);
    chk("hrst_en", bus.o_en_read_data, 0);
    chk("hrst_ready", bus.o_ready, 0);
    chk("hrst_addr", bus.o_addr_ram, 0);
    chk("hrst_data", bus.o_data_ram, 0);
    chk("hrst_si", bus.o_si_ram, 0);
    chk("hrst_ei", bus.o_ei_ram, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.o_ready, 1);
    send(8'h77, 1'b1);
    chk("post_rst_addr", bus.o_addr_ram, 0);
    chk("post_rst_data", bus.o_data_ram, 8'h77);
    chk_frame("post_rst", 6'd0, 6'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
